// File: rtl/controlador_vez.sv
// -----------------------------------------------------------------------------
// controlador_vez -- turn controller for the tic-tac-toe game.
//
// Decides whose turn it is, runs the move handshake with the board datapath,
// enforces a per-turn timeout, counts accepted moves and flags end of game.
//
// Optional feature macro: ALTERNA_INICIO_EN
//   defined   -> the first player alternates P1/P2 on every iniciar
//   undefined -> every game starts with P1 (no starter register)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-low reset
//   iniciar      in   start/restart game (highest priority)
//   jogada       in   move request level, held until ack/nack
//   jogada_ok    in   selected cell is free (valid with jogada)
//   vitoria      in   win detected for the last written move
//   jogador      out  00 idle/tie, 01 P1, 10 P2, 11 error
//   jogada_ack   out  1-cycle pulse, board writes current player's mark
//   jogada_nack  out  1-cycle pulse, move rejected (occupied cell)
//   fim_jogo     out  game over (win, tie or timeout)
//   vencedor     out  00 none/tie, 01 P1, 10 P2
//   num_jogadas  out  accepted moves in the current game, 0..9
//   timeout      out  game ended by turn timeout
// -----------------------------------------------------------------------------
module controlador_vez #(
    parameter int unsigned TIMEOUT = 5000,
    parameter int unsigned TW      = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       jogada_ok,
    input  logic       vitoria,
    output logic [1:0] jogador,
    output logic       jogada_ack,
    output logic       jogada_nack,
    output logic       fim_jogo,
    output logic [1:0] vencedor,
    output logic [3:0] num_jogadas,
    output logic       timeout
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        VEZ    = 3'd1,
        ACK    = 3'd2,
        AVALIA = 3'd3,
        SOLTA  = 3'd4,
        FIM    = 3'd5,
        ERRO   = 3'd6
    } estado_t;

    localparam logic [1:0]    P_NENHUM = 2'b00;
    localparam logic [1:0]    P_UM     = 2'b01;
    localparam logic [1:0]    P_DOIS   = 2'b10;
    localparam logic [1:0]    P_ERRO   = 2'b11;
    localparam logic [3:0]    MAX_JOG  = 4'd9;
    localparam logic [TW-1:0] T_ULTIMO = TW'(TIMEOUT - 1);

    estado_t       estado_q, estado_d;
    logic [1:0]    jogador_q, jogador_d;
    logic [1:0]    vencedor_q, vencedor_d;
    logic [3:0]    num_q, num_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          fim_q, fim_d;
    logic          timeout_q, timeout_d;
`ifdef ALTERNA_INICIO_EN
    logic [1:0]    inicio_q, inicio_d;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; iniciar overrides every other input
    always_comb begin
        estado_d = estado_q;
        if (iniciar) begin
            estado_d = VEZ;
        end else begin
            case (estado_q)
                VEZ: begin
                    // Timeout wins over a move arriving in the same cycle
                    if (timer_q == T_ULTIMO) begin
                        estado_d = ERRO;
                    end else if (jogada) begin
                        estado_d = jogada_ok ? ACK : SOLTA;
                    end
                end
                ACK:    estado_d = AVALIA;
                AVALIA: estado_d = (vitoria || (num_q == MAX_JOG)) ? FIM : SOLTA;
                SOLTA:  if (!jogada) estado_d = VEZ;
                default: estado_d = estado_q;
            endcase
        end
    end

    // Output / datapath next values; pulses are set on the transition so
    // they appear during the following cycle only
    always_comb begin
        jogador_d  = jogador_q;
        vencedor_d = vencedor_q;
        num_d      = num_q;
        timer_d    = timer_q;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
        fim_d      = fim_q;
        timeout_d  = timeout_q;
`ifdef ALTERNA_INICIO_EN
        inicio_d   = inicio_q;
`endif
        if (iniciar) begin
            num_d      = 4'd0;
            vencedor_d = P_NENHUM;
            timer_d    = '0;
            fim_d      = 1'b0;
            timeout_d  = 1'b0;
`ifdef ALTERNA_INICIO_EN
            jogador_d  = inicio_q;
            inicio_d   = (inicio_q == P_UM) ? P_DOIS : P_UM;
`else
            jogador_d  = P_UM;
`endif
        end else begin
            case (estado_q)
                VEZ: begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == T_ULTIMO) begin
                        fim_d      = 1'b1;
                        timeout_d  = 1'b1;
                        jogador_d  = P_ERRO;
                        vencedor_d = P_NENHUM;
                    end else if (jogada) begin
                        ack_d  = jogada_ok;
                        nack_d = !jogada_ok;
                    end
                end
                ACK: begin
                    if (num_q != MAX_JOG) num_d = num_q + 4'd1;
                end
                AVALIA: begin
                    if (vitoria) begin
                        vencedor_d = jogador_q;
                        fim_d      = 1'b1;
                    end else if (num_q == MAX_JOG) begin
                        vencedor_d = P_NENHUM;
                        jogador_d  = P_NENHUM;
                        fim_d      = 1'b1;
                    end else begin
                        jogador_d = (jogador_q == P_UM) ? P_DOIS : P_UM;
                        timer_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            jogador_q  <= P_NENHUM;
            vencedor_q <= P_NENHUM;
            num_q      <= 4'd0;
            timer_q    <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            fim_q      <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ALTERNA_INICIO_EN
            inicio_q   <= P_UM;
`endif
        end else begin
            jogador_q  <= jogador_d;
            vencedor_q <= vencedor_d;
            num_q      <= num_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            fim_q      <= fim_d;
            timeout_q  <= timeout_d;
`ifdef ALTERNA_INICIO_EN
            inicio_q   <= inicio_d;
`endif
        end
    end

    assign jogador     = jogador_q;
    assign vencedor    = vencedor_q;
    assign num_jogadas = num_q;
    assign jogada_ack  = ack_q;
    assign jogada_nack = nack_q;
    assign fim_jogo    = fim_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_controlador_vez.sv
// -----------------------------------------------------------------------------
// tb_controlador_vez -- self-checking bench for controlador_vez.
// Vector layout everywhere: {jogador, ack, nack, fim, vencedor, num, timeout}.
// -----------------------------------------------------------------------------
module tb_controlador_vez;

    localparam int unsigned TO  = 20;
    localparam int unsigned TWB = 5;

`ifdef ALTERNA_INICIO_EN
    localparam logic [1:0] G2 = 2'b10;
`else
    localparam logic [1:0] G2 = 2'b01;
`endif

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada, jogada_ok, vitoria;
    logic [1:0] jogador, vencedor;
    logic       jogada_ack, jogada_nack, fim_jogo, timeout;
    logic [3:0] num_jogadas;

    always #5 clock = ~clock;

    controlador_vez #(.TIMEOUT(TO), .TW(TWB)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .jogada      (jogada),
        .jogada_ok   (jogada_ok),
        .vitoria     (vitoria),
        .jogador     (jogador),
        .jogada_ack  (jogada_ack),
        .jogada_nack (jogada_nack),
        .fim_jogo    (fim_jogo),
        .vencedor    (vencedor),
        .num_jogadas (num_jogadas),
        .timeout     (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Game-level reference: a turn is "open" while a game is active, no move
    // is being processed and no release of the request is awaited.
    logic       m_act, m_over, m_tout, m_wrel, m_ack, m_nack;
    logic [1:0] m_pl, m_win, m_start;
    int         m_moves, m_el, m_stage;

    function automatic logic [11:0] ev(logic [1:0] jg, logic a, logic n, logic f,
                                       logic [1:0] vc, int nm, logic t);
        return {jg, a, n, f, vc, 4'(nm), t};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {jogador, jogada_ack, jogada_nack, fim_jogo, vencedor, num_jogadas, timeout};
    endfunction

    function automatic logic [11:0] mdl_vec();
        return {m_pl, m_ack, m_nack, m_over, m_win, 4'(m_moves), m_tout};
    endfunction

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (jog,ack,nack,fim,venc,num,to)", nm, got, exp);
        end
    endtask

    task automatic mdl_tick(input logic r, input logic ini, input logic jog,
                            input logic ok, input logic vit);
        if (!r) begin
            m_act = 0; m_over = 0; m_tout = 0; m_wrel = 0; m_ack = 0; m_nack = 0;
            m_pl = 2'b00; m_win = 2'b00; m_start = 2'b01;
            m_moves = 0; m_el = 0; m_stage = 0;
        end else if (ini) begin
            m_act = 1; m_over = 0; m_tout = 0; m_wrel = 0; m_ack = 0; m_nack = 0;
            m_win = 2'b00; m_moves = 0; m_el = 0; m_stage = 0;
            m_pl = m_start;
`ifdef ALTERNA_INICIO_EN
            m_start = (m_start == 2'b01) ? 2'b10 : 2'b01;
`endif
        end else begin
            m_ack = 0; m_nack = 0;
            if (m_act) begin
                if (m_stage == 1) begin
                    m_moves++;
                    m_stage = 2;
                end else if (m_stage == 2) begin
                    if (vit) begin
                        m_over = 1; m_win = m_pl; m_act = 0;
                    end else if (m_moves == 9) begin
                        m_over = 1; m_win = 2'b00; m_pl = 2'b00; m_act = 0;
                    end else begin
                        m_pl = (m_pl == 2'b01) ? 2'b10 : 2'b01;
                        m_el = 0; m_wrel = 1; m_stage = 0;
                    end
                end else if (m_wrel) begin
                    if (!jog) m_wrel = 0;
                end else if (m_el == int'(TO) - 1) begin
                    m_act = 0; m_over = 1; m_tout = 1; m_pl = 2'b11; m_win = 2'b00;
                end else begin
                    m_el++;
                    if (jog && ok) begin
                        m_ack = 1; m_stage = 1;
                    end else if (jog) begin
                        m_nack = 1; m_wrel = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive, advance model at the edge, compare 1 time unit later
    task automatic step(input logic r, input logic ini, input logic jog,
                        input logic ok, input logic vit);
        reset = r; iniciar = ini; jogada = jog; jogada_ok = ok; vitoria = vit;
        @(posedge clock);
        mdl_tick(r, ini, jog, ok, vit);
        #1;
        chk("model", dut_vec(), mdl_vec());
    endtask

    typedef struct {
        logic        ini, jog, ok, vit;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(logic ini, logic jog, logic ok, logic vit, logic [11:0] e);
        vec_t v;
        v.ini = ini; v.jog = jog; v.ok = ok; v.vit = vit; v.exp = e;
        return v;
    endfunction

    vec_t tbl[28];
    logic jr;

    initial begin
        reset = 0; iniciar = 0; jogada = 0; jogada_ok = 0; vitoria = 0;

        // First game: handshake, nack, alternation, P1 wins on move 5,
        // then restart and restart-with-simultaneous-move.
        tbl[0]  = mk(1,0,0,0, ev(2'b01,0,0,0,2'b00,0,0));
        tbl[1]  = mk(0,1,1,0, ev(2'b01,1,0,0,2'b00,0,0));
        tbl[2]  = mk(0,1,1,0, ev(2'b01,0,0,0,2'b00,1,0));
        tbl[3]  = mk(0,1,1,0, ev(2'b10,0,0,0,2'b00,1,0));
        tbl[4]  = mk(0,0,0,0, ev(2'b10,0,0,0,2'b00,1,0));
        tbl[5]  = mk(0,1,0,0, ev(2'b10,0,1,0,2'b00,1,0));
        tbl[6]  = mk(0,1,0,0, ev(2'b10,0,0,0,2'b00,1,0));
        tbl[7]  = mk(0,0,0,0, ev(2'b10,0,0,0,2'b00,1,0));
        tbl[8]  = mk(0,1,1,0, ev(2'b10,1,0,0,2'b00,1,0));
        tbl[9]  = mk(0,1,1,0, ev(2'b10,0,0,0,2'b00,2,0));
        tbl[10] = mk(0,0,0,0, ev(2'b01,0,0,0,2'b00,2,0));
        tbl[11] = mk(0,0,0,0, ev(2'b01,0,0,0,2'b00,2,0));
        tbl[12] = mk(0,1,1,0, ev(2'b01,1,0,0,2'b00,2,0));
        tbl[13] = mk(0,0,0,0, ev(2'b01,0,0,0,2'b00,3,0));
        tbl[14] = mk(0,0,0,0, ev(2'b10,0,0,0,2'b00,3,0));
        tbl[15] = mk(0,0,0,0, ev(2'b10,0,0,0,2'b00,3,0));
        tbl[16] = mk(0,1,1,0, ev(2'b10,1,0,0,2'b00,3,0));
        tbl[17] = mk(0,0,0,0, ev(2'b10,0,0,0,2'b00,4,0));
        tbl[18] = mk(0,0,0,0, ev(2'b01,0,0,0,2'b00,4,0));
        tbl[19] = mk(0,0,0,0, ev(2'b01,0,0,0,2'b00,4,0));
        tbl[20] = mk(0,1,1,0, ev(2'b01,1,0,0,2'b00,4,0));
        tbl[21] = mk(0,0,0,0, ev(2'b01,0,0,0,2'b00,5,0));
        tbl[22] = mk(0,0,0,1, ev(2'b01,0,0,1,2'b01,5,0));
        tbl[23] = mk(0,1,1,0, ev(2'b01,0,0,1,2'b01,5,0));
        tbl[24] = mk(1,1,1,0, ev(G2,   0,0,0,2'b00,0,0));
        tbl[25] = mk(0,0,0,0, ev(G2,   0,0,0,2'b00,0,0));
        tbl[26] = mk(1,1,1,0, ev(2'b01,0,0,0,2'b00,0,0));
        tbl[27] = mk(0,1,1,0, ev(2'b01,1,0,0,2'b00,0,0));

        step(0,0,0,0,0);
        step(0,0,0,0,0);
        chk("reset", dut_vec(), 12'd0);
        step(1,0,0,0,0);
        chk("idle_after_reset", dut_vec(), 12'd0);

        for (int i = 0; i < 28; i++) begin
            step(1, tbl[i].ini, tbl[i].jog, tbl[i].ok, tbl[i].vit);
            chk($sformatf("row%0d", i), dut_vec(), tbl[i].exp);
        end

        // Tie: nine accepted moves without a win
        step(0,0,0,0,0);
        step(1,1,0,0,0);
        for (int k = 1; k <= 9; k++) begin
            step(1,0,1,1,0);
            chk($sformatf("tie_ack%0d", k), dut_vec(),
                ev((k % 2 == 1) ? 2'b01 : 2'b10, 1,0,0,2'b00,k-1,0));
            step(1,0,0,0,0);
            step(1,0,0,0,0);
            step(1,0,0,0,0);
        end
        chk("tie_end", dut_vec(), ev(2'b00,0,0,1,2'b00,9,0));
        for (int k = 0; k < 3; k++) begin
            step(1,0,1,(k != 1),0);
            chk($sformatf("tie_ignore%0d", k), dut_vec(), ev(2'b00,0,0,1,2'b00,9,0));
        end

        // Timeout: TO cycles without a move; a move on the last cycle is ignored
        step(0,0,0,0,0);
        step(1,1,0,0,0);
        for (int k = 1; k < int'(TO); k++) step(1,0,0,0,0);
        chk("to_last_cycle", dut_vec(), ev(2'b01,0,0,0,2'b00,0,0));
        step(1,0,1,1,0);
        chk("to_expired", dut_vec(), ev(2'b11,0,0,1,2'b00,0,1));
        step(1,0,1,1,0);
        chk("to_hold", dut_vec(), ev(2'b11,0,0,1,2'b00,0,1));
        step(1,1,0,0,0);
        chk("to_restart", dut_vec(), ev(G2,0,0,0,2'b00,0,0));

        // Randomized play against the reference model
        jr = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(7) == 0) jr = ~jr;
            step($urandom_range(799) != 0, $urandom_range(119) == 0, jr,
                 $urandom_range(3) != 0, $urandom_range(5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
